// File: rtl/ctrl_pkg.sv
// Shared control definitions for the decoder and the ID/EX pipeline register.
// Includes opcodes, ALUOp classes, operand/writeback selects and the EX control bundle.
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] R_OP     = 2'b10;
  localparam logic [1:0] B_OP     = 2'b01;
  localparam logic [1:0] OTHER_OP = 2'b00;

  localparam logic MEMTOREG_MEM = 1'b1;
  localparam logic MEMTOREG_ALU = 1'b0;
  localparam logic ALUSRC_IMM   = 1'b1;
  localparam logic ALUSRC_REG   = 1'b0;

  typedef struct packed {
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NOP = '0;

  // Stores read rs2 as write data even though their ALU operand is the immediate.
  function automatic logic reads_rs2(input logic alu_src, input logic mem_write);
    return (alu_src == ALUSRC_REG) || mem_write;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
// Purely combinational; a flushed ID instruction never stalls.
module hazard_detect
  import ctrl_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_alu_src_i,
  input  logic       id_mem_write_i,
  input  logic       flush_i,
  output logic       stall_o
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = (ex_rd_addr_i == id_rs1_addr_i);
  assign rs2_match = (ex_rd_addr_i == id_rs2_addr_i) && reads_rs2(id_alu_src_i, id_mem_write_i);

  assign stall_o = ex_mem_read_i && (ex_rd_addr_i != 5'd0) && !flush_i && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash
// and a saturating debug count of inserted bubbles.
module id_ex_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic             MemRead_i,
  input  logic             MemtoReg_i,
  input  logic             MemWrite_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic [4:0]       rd_addr_i,
  input  logic [9:0]       funct_i,
  output logic             MemRead_o,
  output logic             MemtoReg_o,
  output logic             MemWrite_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic [1:0]       ALUOp_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  output logic [4:0]       rd_addr_o,
  output logic [9:0]       funct_o,
  output logic             stall_o,
  output logic             pc_write_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ex_ctrl_t   ctrl_q, ctrl_d, ctrl_in;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0] rs1_addr_q, rs1_addr_d;
  logic [4:0] rs2_addr_q, rs2_addr_d;
  logic [4:0] rd_addr_q, rd_addr_d;
  logic [9:0] funct_q, funct_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic       stall;
  logic       bubble;

  assign ctrl_in = '{mem_read:   MemRead_i,
                     mem_to_reg: MemtoReg_i,
                     mem_write:  MemWrite_i,
                     alu_src:    ALUSrc_i,
                     reg_write:  RegWrite_i,
                     alu_op:     ALUOp_i};

  hazard_detect u_hazard_detect (
    .ex_mem_read_i  (ctrl_q.mem_read),
    .ex_rd_addr_i   (rd_addr_q),
    .id_rs1_addr_i  (rs1_addr_i),
    .id_rs2_addr_i  (rs2_addr_i),
    .id_alu_src_i   (ALUSrc_i),
    .id_mem_write_i (MemWrite_i),
    .flush_i        (flush_i),
    .stall_o        (stall)
  );

  assign bubble = flush_i || stall;

  always_comb begin
    ctrl_d       = ctrl_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    rd_addr_d    = rd_addr_q;
    funct_d      = funct_q;
    bubble_cnt_d = bubble_cnt_q;
    if (start_i) begin
      if (bubble) begin
        // A bubble is a fully zeroed slot, not just cleared control.
        ctrl_d     = EX_CTRL_NOP;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rs1_addr_d = '0;
        rs2_addr_d = '0;
        rd_addr_d  = '0;
        funct_d    = '0;
        if (bubble_cnt_q != {CNT_W{1'b1}}) begin
          bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
      end else begin
        ctrl_d     = ctrl_in;
        rs1_data_d = rs1_data_i;
        rs2_data_d = rs2_data_i;
        imm_d      = imm_i;
        rs1_addr_d = rs1_addr_i;
        rs2_addr_d = rs2_addr_i;
        rd_addr_d  = rd_addr_i;
        funct_d    = funct_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctrl_q       <= EX_CTRL_NOP;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      funct_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rd_addr_q    <= rd_addr_d;
      funct_q      <= funct_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign MemRead_o    = ctrl_q.mem_read;
  assign MemtoReg_o   = ctrl_q.mem_to_reg;
  assign MemWrite_o   = ctrl_q.mem_write;
  assign ALUSrc_o     = ctrl_q.alu_src;
  assign RegWrite_o   = ctrl_q.reg_write;
  assign ALUOp_o      = ctrl_q.alu_op;
  assign rs1_data_o   = rs1_data_q;
  assign rs2_data_o   = rs2_data_q;
  assign imm_o        = imm_q;
  assign rs1_addr_o   = rs1_addr_q;
  assign rs2_addr_o   = rs2_addr_q;
  assign rd_addr_o    = rd_addr_q;
  assign funct_o      = funct_q;
  assign stall_o      = stall;
  assign pc_write_o   = ~stall;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: per-cycle comparison against an ISA-level model
// plus hand-computed checkpoints; a second instance with a 2-bit counter covers saturation.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  // Control packing used by the bench: {MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp}
  localparam logic [6:0] C_NOP  = 7'b0000000;
  localparam logic [6:0] C_R    = 7'b0000110;
  localparam logic [6:0] C_LW   = 7'b1101100;
  localparam logic [6:0] C_ADDI = 7'b0001100;
  localparam logic [6:0] C_SW   = 7'b0011000;

  logic clk, rst, start, flush;
  logic [6:0] ctl;
  logic [XLEN-1:0] rs1d, rs2d, imm;
  logic [4:0] rs1a, rs2a, rda;
  logic [9:0] funct;

  logic mr_o, m2r_o, mw_o, as_o, rw_o;
  logic [1:0] aluop_o;
  logic [XLEN-1:0] rs1d_o, rs2d_o, imm_o;
  logic [4:0] rs1a_o, rs2a_o, rda_o;
  logic [9:0] funct_o;
  logic stall_o, pcw_o;
  logic [15:0] cnt_o;

  logic d2_mr, d2_m2r, d2_mw, d2_as, d2_rw;
  logic [1:0] d2_aluop;
  logic [XLEN-1:0] d2_rs1d, d2_rs2d, d2_imm;
  logic [4:0] d2_rs1a, d2_rs2a, d2_rda;
  logic [9:0] d2_funct;
  logic d2_stall, d2_pcw;
  logic [1:0] d2_cnt;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 0;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .MemRead_i(ctl[6]), .MemtoReg_i(ctl[5]), .MemWrite_i(ctl[4]), .ALUSrc_i(ctl[3]),
    .RegWrite_i(ctl[2]), .ALUOp_i(ctl[1:0]),
    .rs1_data_i(rs1d), .rs2_data_i(rs2d), .imm_i(imm),
    .rs1_addr_i(rs1a), .rs2_addr_i(rs2a), .rd_addr_i(rda), .funct_i(funct),
    .MemRead_o(mr_o), .MemtoReg_o(m2r_o), .MemWrite_o(mw_o), .ALUSrc_o(as_o),
    .RegWrite_o(rw_o), .ALUOp_o(aluop_o),
    .rs1_data_o(rs1d_o), .rs2_data_o(rs2d_o), .imm_o(imm_o),
    .rs1_addr_o(rs1a_o), .rs2_addr_o(rs2a_o), .rd_addr_o(rda_o), .funct_o(funct_o),
    .stall_o(stall_o), .pc_write_o(pcw_o), .bubble_cnt_o(cnt_o)
  );

  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .MemRead_i(ctl[6]), .MemtoReg_i(ctl[5]), .MemWrite_i(ctl[4]), .ALUSrc_i(ctl[3]),
    .RegWrite_i(ctl[2]), .ALUOp_i(ctl[1:0]),
    .rs1_data_i(rs1d), .rs2_data_i(rs2d), .imm_i(imm),
    .rs1_addr_i(rs1a), .rs2_addr_i(rs2a), .rd_addr_i(rda), .funct_i(funct),
    .MemRead_o(d2_mr), .MemtoReg_o(d2_m2r), .MemWrite_o(d2_mw), .ALUSrc_o(d2_as),
    .RegWrite_o(d2_rw), .ALUOp_o(d2_aluop),
    .rs1_data_o(d2_rs1d), .rs2_data_o(d2_rs2d), .imm_o(d2_imm),
    .rs1_addr_o(d2_rs1a), .rs2_addr_o(d2_rs2a), .rd_addr_o(d2_rda), .funct_o(d2_funct),
    .stall_o(d2_stall), .pc_write_o(d2_pcw), .bubble_cnt_o(d2_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // ---- behavioural model: contents of the EX slot and bubble tallies ----
  logic [6:0] m_ctl;
  logic [XLEN-1:0] m_rs1d, m_rs2d, m_imm;
  logic [4:0] m_rs1a, m_rs2a, m_rd;
  logic [9:0] m_funct;
  int m_cnt, m_cnt2;

  function automatic bit m_stall();
    bit ex_is_load = m_ctl[6];
    bit id_uses_rs2 = !ctl[3] || ctl[4];
    return ex_is_load && m_rd != 0 && !flush &&
           (m_rd == rs1a || (m_rd == rs2a && id_uses_rs2));
  endfunction

  always @(posedge clk) begin
    bit b;
    b = flush || m_stall();
    if (!rst) begin
      m_ctl = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
      m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_funct = 0;
      m_cnt = 0; m_cnt2 = 0;
    end else if (start) begin
      if (b) begin
        m_ctl = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
        m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_funct = 0;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      end else begin
        m_ctl = ctl; m_rs1d = rs1d; m_rs2d = rs2d; m_imm = imm;
        m_rs1a = rs1a; m_rs2a = rs2a; m_rd = rda; m_funct = funct;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit s;
      s = m_stall();
      chk("ctrl", 64'({mr_o, m2r_o, mw_o, as_o, rw_o, aluop_o}), 64'(m_ctl));
      chk("rs1_data", 64'(rs1d_o), 64'(m_rs1d));
      chk("rs2_data", 64'(rs2d_o), 64'(m_rs2d));
      chk("imm", 64'(imm_o), 64'(m_imm));
      chk("addrs", 64'({rs1a_o, rs2a_o, rda_o}), 64'({m_rs1a, m_rs2a, m_rd}));
      chk("funct", 64'(funct_o), 64'(m_funct));
      chk("stall", 64'(stall_o), 64'(s));
      chk("pc_write", 64'(pcw_o), 64'(!s));
      chk("bubble_cnt", 64'(cnt_o), 64'(m_cnt));
      chk("bubble_cnt2", 64'(d2_cnt), 64'(m_cnt2));
    end
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] c, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] im, input logic [9:0] fn);
    ctl = c; rs1a = r1; rs2a = r2; rda = rd; rs1d = d1; rs2d = d2; imm = im; funct = fn;
  endtask

  initial begin
    rst = 0; start = 1; flush = 0;
    set_in(C_LW, 5'd9, 5'd10, 5'd11, 32'hdead, 32'hbeef, 32'h44, 10'h3ff);

    // reset with non-zero inputs for two cycles
    tick();
    chk_en = 1;
    tick();
    #2;
    chk("reset_ctrl", 64'({mr_o, m2r_o, mw_o, as_o, rw_o, aluop_o}), 64'd0);
    chk("reset_rd", 64'(rda_o), 64'd0);
    chk("reset_pcw", 64'(pcw_o), 64'd1);
    chk("reset_cnt", 64'(cnt_o), 64'd0);

    // R-type pass-through
    rst = 1;
    set_in(C_R, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h0, 10'h000);
    tick();
    set_in(C_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #2;
    chk("pass_rs1d", 64'(rs1d_o), 64'h11);
    chk("pass_rs2d", 64'(rs2d_o), 64'h22);
    chk("pass_rd", 64'(rda_o), 64'd5);
    chk("pass_aluop", 64'(aluop_o), 64'd2);
    chk("pass_stall", 64'(stall_o), 64'd0);

    // lw x5 ; add x6, x5, x7 -> one stall cycle
    set_in(C_LW, 5'd1, 5'd0, 5'd5, 32'h100, 0, 32'h4, 10'h002);
    tick();
    set_in(C_R, 5'd5, 5'd7, 5'd6, 32'h55, 32'h77, 0, 10'h000);
    #2;
    chk("lu_stall", 64'(stall_o), 64'd1);
    chk("lu_pcw", 64'(pcw_o), 64'd0);
    tick();
    #2;
    chk("lu_bubble_mr", 64'(mr_o), 64'd0);
    chk("lu_bubble_rd", 64'(rda_o), 64'd0);
    chk("lu_stall_gone", 64'(stall_o), 64'd0);
    chk("lu_cnt", 64'(cnt_o), 64'd1);
    tick();
    set_in(C_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #2;
    chk("lu_add_rd", 64'(rda_o), 64'd6);
    chk("lu_add_rs1", 64'(rs1a_o), 64'd5);

    // lw x5 ; addi x6, x0, 1 with rs2 field = 5 -> no stall
    set_in(C_LW, 5'd1, 5'd0, 5'd5, 0, 0, 32'h8, 10'h002);
    tick();
    set_in(C_ADDI, 5'd0, 5'd5, 5'd6, 0, 0, 32'h1, 10'h000);
    #2;
    chk("addi_nostall", 64'(stall_o), 64'd0);
    tick();

    // lw x5 ; sw x5, 0(x1) -> stall
    set_in(C_LW, 5'd1, 5'd0, 5'd5, 0, 0, 32'h8, 10'h002);
    tick();
    set_in(C_SW, 5'd1, 5'd5, 5'd0, 32'h1000, 32'h5, 32'h0, 10'h002);
    #2;
    chk("sw_stall", 64'(stall_o), 64'd1);
    tick();
    #2;
    chk("sw_cnt", 64'(cnt_o), 64'd2);
    tick();
    set_in(C_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #2;
    chk("sw_latched", 64'(mw_o), 64'd1);

    // flush in the same cycle as a load-use match
    set_in(C_LW, 5'd1, 5'd0, 5'd5, 0, 0, 32'h8, 10'h002);
    tick();
    set_in(C_R, 5'd5, 5'd7, 5'd6, 32'h55, 32'h77, 0, 10'h000);
    flush = 1;
    #2;
    chk("flush_nostall", 64'(stall_o), 64'd0);
    tick();
    flush = 0;
    set_in(C_R, 5'd2, 5'd3, 5'd9, 32'haa, 32'hbb, 0, 10'h20);
    #2;
    chk("flush_bubble", 64'(mr_o), 64'd0);
    chk("flush_cnt", 64'(cnt_o), 64'd3);

    // hold for three cycles, even with flush asserted
    tick();
    start = 0;
    flush = 1;
    set_in(C_LW, 5'd9, 5'd9, 5'd12, 32'h1, 32'h2, 32'h3, 10'h1);
    repeat (3) tick();
    #2;
    chk("hold_rd", 64'(rda_o), 64'd9);
    chk("hold_rs1d", 64'(rs1d_o), 64'haa);
    chk("hold_cnt", 64'(cnt_o), 64'd3);
    start = 1;
    flush = 0;

    // lw x0 ; use of x0 -> no stall
    set_in(C_LW, 5'd1, 5'd0, 5'd0, 0, 0, 0, 10'h002);
    tick();
    set_in(C_R, 5'd0, 5'd0, 5'd6, 0, 0, 0, 0);
    #2;
    chk("x0_nostall", 64'(stall_o), 64'd0);
    tick();

    // reset asserted mid-stall with start low
    set_in(C_LW, 5'd1, 5'd0, 5'd5, 0, 0, 32'h8, 10'h002);
    tick();
    set_in(C_R, 5'd5, 5'd7, 5'd6, 32'h55, 32'h77, 0, 0);
    #2;
    chk("mid_stall", 64'(stall_o), 64'd1);
    rst = 0;
    start = 0;
    tick();
    #2;
    chk("mid_rst_mr", 64'(mr_o), 64'd0);
    chk("mid_rst_cnt", 64'(cnt_o), 64'd0);

    // five flushes: wide counter counts, 2-bit counter saturates at 3
    rst = 1;
    start = 1;
    flush = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      #2;
      chk("sat_cnt16", 64'(cnt_o), 64'(i));
      chk("sat_cnt2", 64'(d2_cnt), 64'(i > 3 ? 3 : i));
    end
    flush = 0;
    tick();
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
